fifo_port_arbiter: RTL

Front-end controller that shares one FIFO between two independent push requesters and one pop requester. It serialises all FIFO accesses through a small Moore state machine and picks between the two writers round-robin. Reads and writes alternate when both are ready. A stall watchdog raises a sticky error when a request stays blocked by full/empty. It sits between the switch/button-level request logic and the FIFO's `wr`/`rd`/`full`/`empty` ports.

---
 rtl/fifo_port_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/fifo_port_arbiter.sv
// Serialises two round-robin push requesters and one pop requester onto a single FIFO.
// Moore FSM: every strobe and grant is decoded from registered state.
//
// state  | meaning
// IDLE   | sample requests and FIFO flags, pick the next operation
// WRITE  | fifo_wr and the selected writer's gnt are high
// READ   | fifo_rd and rd_gnt are high
// SETTLE | no strobes; gives the FIFO flags a cycle to update
module fifo_port_arbiter #(
    parameter int W         = 3,
    parameter int STALL_MAX = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req0,
    input  logic [W-1:0] din0,
    output logic         gnt0,
    input  logic         req1,
    input  logic [W-1:0] din1,
    output logic         gnt1,
    input  logic         rd_req,
    output logic         rd_gnt,
    output logic         fifo_wr,
    output logic [W-1:0] fifo_wdata,
    output logic         fifo_rd,
    input  logic         fifo_full,
    input  logic         fifo_empty,
    input  logic         err_clr,
    output logic         stall_err,
    output logic         busy
);

    localparam int CW = $clog2(STALL_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_SETTLE
    } state_t;

    state_t         state_q, state_d;
    logic           sel_q, sel_d;
    logic           last_w_q, last_w_d;
    logic           last_class_q, last_class_d;   // 1: last served was a write
    logic [W-1:0]   wdata_q, wdata_d;
    logic [CW-1:0]  stall_cnt_q, stall_cnt_d;
    logic           stall_err_q, stall_err_d;

    logic wr_ok, rd_ok, blocked;

    assign wr_ok   = (req0 | req1) & ~fifo_full;
    assign rd_ok   = rd_req & ~fifo_empty;
    assign blocked = ((req0 | req1) & fifo_full) | (rd_req & fifo_empty);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_w_d     = last_w_q;
        last_class_d = last_class_q;
        wdata_d      = wdata_q;
        stall_cnt_d  = stall_cnt_q;
        stall_err_d  = stall_err_q;

        case (state_q)
            S_IDLE: begin
                if (wr_ok && (!rd_ok || !last_class_q)) begin
                    state_d = S_WRITE;
                    if (req0 && req1) begin
                        sel_d = ~last_w_q;
                    end else begin
                        sel_d = req1;
                    end
                    wdata_d = sel_d ? din1 : din0;
                end else if (rd_ok) begin
                    state_d = S_READ;
                end

                if (state_d != S_IDLE || !blocked) begin
                    stall_cnt_d = '0;
                end else if (stall_cnt_q != CW'(STALL_MAX)) begin
                    stall_cnt_d = stall_cnt_q + 1'b1;
                end
            end
            S_WRITE: begin
                last_w_d     = sel_q;
                last_class_d = 1'b1;
                state_d      = S_SETTLE;
            end
            S_READ: begin
                last_class_d = 1'b0;
                state_d      = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stall_cnt_d == CW'(STALL_MAX)) begin
            stall_err_d = 1'b1;
        end
        // clear has priority over a same-cycle set
        if (err_clr) begin
            stall_cnt_d = '0;
            stall_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b0;
            last_w_q     <= 1'b1;
            last_class_q <= 1'b0;
            wdata_q      <= '0;
            stall_cnt_q  <= '0;
            stall_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_w_q     <= last_w_d;
            last_class_q <= last_class_d;
            wdata_q      <= wdata_d;
            stall_cnt_q  <= stall_cnt_d;
            stall_err_q  <= stall_err_d;
        end
    end

    assign fifo_wr    = (state_q == S_WRITE);
    assign fifo_rd    = (state_q == S_READ);
    assign gnt0       = fifo_wr & ~sel_q;
    assign gnt1       = fifo_wr & sel_q;
    assign rd_gnt     = fifo_rd;
    assign busy       = (state_q != S_IDLE);
    assign fifo_wdata = wdata_q;
    assign stall_err  = stall_err_q;

endmodule
